// File: rtl/opb_scratch_pkg.sv
// ----------------------------------------------------------------------------
// opb_scratch_pkg
//   Shared definitions for the OPB scratch register bank: word-address map,
//   lock FSM state type, unlock key values and a byte-enable merge helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package opb_scratch_pkg;

    localparam int unsigned ADDR_VERSION = 0;
    localparam int unsigned ADDR_ID      = 1;
    localparam int unsigned ADDR_DATE    = 2;
    localparam int unsigned ADDR_CTRL    = 3;
    localparam int unsigned ADDR_WR_CNT  = 4;
    localparam int unsigned ADDR_SCRATCH = 5;

    localparam logic [31:0] KEY1 = 32'h0000_C0DE;
    localparam logic [31:0] KEY2 = 32'h0000_5AFE;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1_OK  = 2'd1,
        UNLOCKED = 2'd2
    } lock_state_t;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_scratch_bank_if.sv
// ----------------------------------------------------------------------------
// opb_scratch_bank_if
//   Bus bundle between an OPB-side master and the scratch bank.
//   OPB_ADDR [31:0] word address       (master -> slave)
//   SP_DI    [31:0] write data         (master -> slave)
//   SP_BE    [3:0]  write byte enables (master -> slave)
//   SP_RE           read request       (master -> slave)
//   SP_WE           write request      (master -> slave)
//   SP_DO    [31:0] read data          (slave -> master)
//   SP_ACK          completion pulse   (slave -> master)
//   SP_ERR          error flag         (slave -> master)
// ----------------------------------------------------------------------------
interface opb_scratch_bank_if;

    logic [31:0] OPB_ADDR;
    logic [31:0] SP_DI;
    logic [3:0]  SP_BE;
    logic        SP_RE;
    logic        SP_WE;
    logic [31:0] SP_DO;
    logic        SP_ACK;
    logic        SP_ERR;

    modport master (
        output OPB_ADDR, SP_DI, SP_BE, SP_RE, SP_WE,
        input  SP_DO, SP_ACK, SP_ERR
    );

    modport slave (
        input  OPB_ADDR, SP_DI, SP_BE, SP_RE, SP_WE,
        output SP_DO, SP_ACK, SP_ERR
    );

endinterface

// File: rtl/opb_scratch_lock.sv
// ----------------------------------------------------------------------------
// opb_scratch_lock
//   Two-key unlock FSM guarding the scratch registers.
//   OPB_CLK         clock (rising edge)
//   OPB_RST_N       asynchronous active-low reset
//   ctrl_wr         accepted write to the CTRL register this cycle
//   other_req       any other accepted request this cycle
//   wdata [31:0]    write data of the request
//   be    [3:0]     byte enables of the request
//   state           current lock state
//   locked          1 unless UNLOCKED
// ----------------------------------------------------------------------------
module opb_scratch_lock
    import opb_scratch_pkg::*;
#(
    parameter bit LOCK_AT_RESET = 1'b1
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST_N,
    input  logic        ctrl_wr,
    input  logic        other_req,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output lock_state_t state,
    output logic        locked
);

    localparam lock_state_t RESET_STATE = LOCK_AT_RESET ? LOCKED : UNLOCKED;

    lock_state_t state_q;
    lock_state_t state_d;

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Keys must arrive as two consecutive requests; anything else in
    // between drops the sequence back to LOCKED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKED: begin
                if (ctrl_wr && be == 4'hF && wdata == KEY1) begin
                    state_d = KEY1_OK;
                end
            end
            KEY1_OK: begin
                if (ctrl_wr && be == 4'hF && wdata == KEY2) begin
                    state_d = UNLOCKED;
                end else if (ctrl_wr || other_req) begin
                    state_d = LOCKED;
                end
            end
            UNLOCKED: begin
                if (ctrl_wr && wdata[0]) begin
                    state_d = LOCKED;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_comb begin
        state  = state_q;
        locked = (state_q != UNLOCKED);
    end

endmodule

// File: rtl/opb_scratch_bank.sv
// ----------------------------------------------------------------------------
// opb_scratch_bank
//   Register bank: read-only VERSION/ID/DATE, lock CTRL register, optional
//   scratch write counter and NUM_SP lock-protected scratch registers.
//   Every request gets a registered ACK exactly one cycle later.
//   OPB_CLK      clock (rising edge)
//   OPB_RST_N    asynchronous active-low reset
//   bus          opb_scratch_bank_if.slave (address, data, enables, RE/WE,
//                read data, ACK, ERR)
//   Build option: define SP_WR_COUNTER_EN to map the WR_CNT register at
//   word address 4; otherwise address 4 is unmapped.
// ----------------------------------------------------------------------------
module opb_scratch_bank
    import opb_scratch_pkg::*;
#(
    parameter logic [31:0] VERSION       = 32'h1234_5678,
    parameter logic [31:0] ID            = 32'h0000_0050,
    parameter logic [31:0] DATE          = 32'h2025_0714,
    parameter int          ADDR_W        = 5,
    parameter int          NUM_SP        = 8,
    parameter int          LOCK_AT_RESET = 1
) (
    input  logic              OPB_CLK,
    input  logic              OPB_RST_N,
    opb_scratch_bank_if.slave bus
);

    logic [31:0] addr;
    logic        unused_addr;
    logic        req_any, req_both, rd, wr;
    logic        ctrl_wr, other_req;
    logic        is_scratch;
    logic        sp_wr, cnt_clr;
    logic        resp_err;
    logic [31:0] rd_data, sp_rd;
    logic [31:0] do_q;
    logic        ack_q, err_q;
    logic [31:0] scratch [NUM_SP];
    lock_state_t state;
    logic        locked;

    assign addr        = 32'(bus.OPB_ADDR[ADDR_W-1:0]);
    assign unused_addr = ^bus.OPB_ADDR;

    assign req_any  = bus.SP_RE | bus.SP_WE;
    assign req_both = bus.SP_RE & bus.SP_WE;
    assign rd       = bus.SP_RE & ~bus.SP_WE;
    assign wr       = bus.SP_WE & ~bus.SP_RE;

    // A simultaneous read+write changes nothing, so it is hidden from the FSM.
    assign ctrl_wr   = wr && (addr == ADDR_CTRL);
    assign other_req = req_any && !req_both && !ctrl_wr;

    assign is_scratch = (addr >= ADDR_SCRATCH) && (addr < ADDR_SCRATCH + NUM_SP);

    opb_scratch_lock #(
        .LOCK_AT_RESET (LOCK_AT_RESET != 0)
    ) u_lock (
        .OPB_CLK   (OPB_CLK),
        .OPB_RST_N (OPB_RST_N),
        .ctrl_wr   (ctrl_wr),
        .other_req (other_req),
        .wdata     (bus.SP_DI),
        .be        (bus.SP_BE),
        .state     (state),
        .locked    (locked)
    );

`ifdef SP_WR_COUNTER_EN
    logic [31:0] wr_cnt;

    // A clear is a write to address 4 and a count is a scratch write, so
    // both can never happen in one cycle.
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            wr_cnt <= '0;
        end else if (cnt_clr) begin
            wr_cnt <= '0;
        end else if (sp_wr) begin
            wr_cnt <= wr_cnt + 32'd1;
        end
    end
`else
    // No counter: address 4 decodes as unmapped below.
`endif

    always_comb begin
        sp_rd = '0;
        for (int i = 0; i < NUM_SP; i++) begin
            if (addr == 32'(ADDR_SCRATCH + i)) begin
                sp_rd = scratch[i];
            end
        end
    end

    // Decode one request into its read data, error flag and side effects.
    // Writes and errors always return zero data.
    always_comb begin
        rd_data  = '0;
        resp_err = 1'b0;
        sp_wr    = 1'b0;
        cnt_clr  = 1'b0;
        if (req_both) begin
            resp_err = 1'b1;
        end else if (rd) begin
            if (addr == ADDR_VERSION) begin
                rd_data = VERSION;
            end else if (addr == ADDR_ID) begin
                rd_data = ID;
            end else if (addr == ADDR_DATE) begin
                rd_data = DATE;
            end else if (addr == ADDR_CTRL) begin
                rd_data = {29'b0, state, locked};
`ifdef SP_WR_COUNTER_EN
            end else if (addr == ADDR_WR_CNT) begin
                rd_data = wr_cnt;
`endif
            end else if (is_scratch) begin
                rd_data = sp_rd;
            end else begin
                resp_err = 1'b1;
            end
        end else if (wr) begin
            if (addr == ADDR_CTRL) begin
                resp_err = 1'b0;
`ifdef SP_WR_COUNTER_EN
            end else if (addr == ADDR_WR_CNT) begin
                cnt_clr = 1'b1;
`endif
            end else if (is_scratch && !locked) begin
                sp_wr = 1'b1;
            end else begin
                resp_err = 1'b1;
            end
        end
    end

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            for (int i = 0; i < NUM_SP; i++) begin
                scratch[i] <= 32'h5A5A_0000 + 32'(i);
            end
        end else begin
            for (int i = 0; i < NUM_SP; i++) begin
                if (sp_wr && addr == 32'(ADDR_SCRATCH + i)) begin
                    scratch[i] <= be_merge(scratch[i], bus.SP_DI, bus.SP_BE);
                end
            end
        end
    end

    // rd_data is zero for idle cycles, so SP_DO is zero whenever ACK is low.
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            do_q  <= '0;
        end else begin
            ack_q <= req_any;
            err_q <= req_any & resp_err;
            do_q  <= rd_data;
        end
    end

    assign bus.SP_DO  = do_q;
    assign bus.SP_ACK = ack_q;
    assign bus.SP_ERR = err_q;

endmodule

// File: tb/tb_opb_scratch_bank.sv
// ----------------------------------------------------------------------------
// tb_opb_scratch_bank
//   Scoreboard bench for opb_scratch_bank (default parameters). Requests are
//   driven on the falling edge; a behavioural model predicts each response
//   and queues it; a monitor on the falling edge pops and compares whenever
//   SP_ACK is seen. Honours SP_WR_COUNTER_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_opb_scratch_bank;

    localparam int          ADDR_W = 5;
    localparam int          NUM_SP = 8;
    localparam logic [31:0] K1     = 32'h0000_C0DE;
    localparam logic [31:0] K2     = 32'h0000_5AFE;

    typedef struct {
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    // Reference model state: lock 0=LOCKED 1=KEY1_OK 2=UNLOCKED.
    logic [31:0] m_sp [NUM_SP];
    int          m_lock;
    logic [31:0] m_cnt;

    opb_scratch_bank_if bus();

    opb_scratch_bank dut (
        .OPB_CLK   (clk),
        .OPB_RST_N (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_SP; i++) m_sp[i] = 32'h5A5A_0000 + i;
        m_lock = 0;
        m_cnt  = 0;
    endtask

    // Predict the response using the pre-request state, then apply effects.
    task automatic modelRequest(input bit re, input bit we, input logic [31:0] addr,
                                input logic [31:0] di, input logic [3:0] be,
                                output logic [31:0] exp_do, output bit exp_err);
        int a;
        bit cnt_en;
        a = int'(addr % (1 << ADDR_W));
        exp_do = 0;
        exp_err = 0;
`ifdef SP_WR_COUNTER_EN
        cnt_en = 1;
`else
        cnt_en = 0;
`endif
        if (re && we) begin
            exp_err = 1;
            return;
        end
        if (re) begin
            if (a == 0) exp_do = 32'h1234_5678;
            else if (a == 1) exp_do = 32'h0000_0050;
            else if (a == 2) exp_do = 32'h2025_0714;
            else if (a == 3) exp_do = 32'(m_lock * 2 + (m_lock != 2 ? 1 : 0));
            else if (a == 4 && cnt_en) exp_do = m_cnt;
            else if (a >= 5 && a < 5 + NUM_SP) exp_do = m_sp[a-5];
            else exp_err = 1;
        end else begin
            if (a == 3) exp_err = 0;
            else if (a == 4 && cnt_en) m_cnt = 0;
            else if (a >= 5 && a < 5 + NUM_SP && m_lock == 2) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_sp[a-5][8*b +: 8] = di[8*b +: 8];
                m_cnt = m_cnt + 1;
            end else exp_err = 1;
        end
        if (m_lock == 1) begin
            m_lock = (we && a == 3 && be == 4'hF && di == K2) ? 2 : 0;
        end else if (m_lock == 0) begin
            if (we && a == 3 && be == 4'hF && di == K1) m_lock = 1;
        end else if (we && a == 3 && di[0]) begin
            m_lock = 0;
        end
    endtask

    task automatic applyStimulus(input bit re, input bit we, input logic [31:0] addr,
                                 input logic [31:0] di, input logic [3:0] be);
        exp_t e;
        @(negedge clk);
        bus.SP_RE    = re;
        bus.SP_WE    = we;
        bus.OPB_ADDR = addr;
        bus.SP_DI    = di;
        bus.SP_BE    = be;
        if (re || we) begin
            modelRequest(re, we, addr, di, be, e.data, e.err);
            e.cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every ACK must match the oldest prediction and land exactly
    // one cycle after its request; idle cycles must show zero data.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checkOutput("ack_in_reset", {31'b0, bus.SP_ACK}, 32'd0);
        end else if (bus.SP_ACK) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("do", bus.SP_DO, e.data);
                checkOutput("err", {31'b0, bus.SP_ERR}, {31'b0, e.err});
                checkOutput("ack_latency", cyc, e.cyc + 1);
            end
        end else begin
            checkOutput("do_idle", bus.SP_DO, 32'd0);
            if (sb_q.size() != 0 && sb_q[0].cyc + 1 <= cyc) begin
                checkOutput("missing_ack", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.SP_RE = 0; bus.SP_WE = 0; bus.OPB_ADDR = 0; bus.SP_DI = 0; bus.SP_BE = 0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", {31'b0, bus.SP_ACK}, 32'd0);
        checkOutput("reset_err", {31'b0, bus.SP_ERR}, 32'd0);
        checkOutput("reset_do", bus.SP_DO, 32'd0);
        rst_n = 1'b1;

        // Identification and CTRL after reset.
        for (int a = 0; a < 4; a++) applyStimulus(1, 0, a, 0, 0);
        // Locked scratch write is rejected.
        applyStimulus(0, 1, 5, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(1, 0, 5, 0, 0);
        // Unlock, check CTRL, partial byte write.
        applyStimulus(0, 1, 3, K1, 4'hF);
        applyStimulus(0, 1, 3, K2, 4'hF);
        applyStimulus(1, 0, 3, 0, 0);
        applyStimulus(0, 1, 5, 32'h1111_2222, 4'b0011);
        applyStimulus(1, 0, 5, 0, 0);
        applyStimulus(0, 1, 6, 32'hFFFF_FFFF, 4'h0);
        applyStimulus(1, 0, 6, 0, 0);
        // Relock, then an interrupted key sequence.
        applyStimulus(0, 1, 3, 32'h1, 4'hF);
        applyStimulus(0, 1, 3, K1, 4'hF);
        applyStimulus(1, 0, 3, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 3, K2, 4'hF);
        applyStimulus(1, 0, 3, 0, 0);
        // Simultaneous RE/WE, read-only writes and unmapped accesses.
        applyStimulus(1, 1, 5, 32'h0BAD_0BAD, 4'hF);
        applyStimulus(1, 0, 5, 0, 0);
        applyStimulus(0, 1, 0, 32'h1, 4'hF);
        applyStimulus(1, 0, 31, 0, 0);
        applyStimulus(1, 0, 4, 0, 0);
        applyStimulus(0, 1, 4, 0, 4'hF);
        applyStimulus(1, 0, 32'hFFFF_FFE1, 0, 0);
        idle(2);
`ifdef SP_WR_COUNTER_EN
        applyStimulus(0, 1, 3, K1, 4'hF);
        applyStimulus(0, 1, 3, K2, 4'hF);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 7 + i, 32'hC0FF_EE00 + i, 4'hF);
        applyStimulus(1, 0, 4, 0, 0);
        applyStimulus(0, 1, 4, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(1, 0, 4, 0, 0);
        idle(1);
`endif

        // Reset while an ACK is on the bus: it must drop at once.
        applyStimulus(1, 0, 1, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_drop_ack", {31'b0, bus.SP_ACK}, 32'd0);
        checkOutput("rst_drop_do", bus.SP_DO, 32'd0);
        bus.SP_RE = 0; bus.SP_WE = 0;
        sb_q.delete();
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 5, 0, 0);
        applyStimulus(1, 0, 3, 0, 0);

        // Randomised traffic, biased toward scratch and key sequences.
        for (int n = 0; n < 600; n++) begin
            int          op;
            int          lo;
            logic [31:0] a;
            op = $urandom_range(0, 99);
            lo = (op % 2 == 1) ? $urandom_range(5, 12) : $urandom_range(0, 31);
            a  = ($urandom << ADDR_W) | 32'(lo);
            if (op < 10) begin
                applyStimulus(0, 1, 3, K1, 4'hF);
                applyStimulus(0, 1, 3, K2, 4'hF);
            end else if (op < 14) begin
                applyStimulus(0, 1, 3, $urandom, $urandom);
            end else if (op < 20) begin
                idle(1);
            end else if (op < 24) begin
                applyStimulus(1, 1, a, $urandom, $urandom);
            end else if (op < 60) begin
                applyStimulus(1, 0, a, $urandom, $urandom);
            end else if (op < 90) begin
                applyStimulus(0, 1, a, $urandom, 4'($urandom));
            end else begin
                applyStimulus(0, 1, a, $urandom, 4'hF);
            end
        end

        idle(3);
        checkOutput("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_scratch_bank.md
OPB_SCRATCH_BANK -- requirements
Module: opb_scratch_bank

Interface
REQ-001 SHALL have parameter VERSION, default 32'h1234_5678, FPGA version (read-only).
REQ-002 SHALL have parameter ID, default 32'h0000_0050, FPGA ID (read-only).
REQ-003 SHALL have parameter DATE, default 32'h2025_0714, build date YYYYMMDD (read-only).
REQ-004 SHALL have parameter ADDR_W, default 5, decoded word-address width.
REQ-005 SHALL have parameter NUM_SP, default 8, scratch register count; legal range 1..(2**ADDR_W - 5).
REQ-006 SHALL have parameter LOCK_AT_RESET, default 1, lock state after reset.
REQ-007 OPB_CLK  input  1  the single clock; all logic rising-edge.
REQ-008 OPB_RST_N  input  1  reset, asynchronous assert, active-low.
REQ-009 OPB_ADDR  input  32  word address; only [ADDR_W-1:0] decoded.
REQ-010 SP_DI  input  32  write data.
REQ-011 SP_BE  input  4  byte enables for writes; bit n covers [8n+7:8n].
REQ-012 SP_RE  input  1  read request, sampled each cycle.
REQ-013 SP_WE  input  1  write request, sampled each cycle.
REQ-014 SP_DO  output  32  registered read data, valid with SP_ACK.
REQ-015 SP_ACK  output  1  one-cycle completion pulse.
REQ-016 SP_ERR  output  1  error flag, valid with SP_ACK.

Function
REQ-017 Map: 0 VERSION, 1 ID, 2 DATE, 3 CTRL, 4 WR_CNT, 5..4+NUM_SP scratch[0..NUM_SP-1]; all others unmapped.
REQ-018 Each cycle with SP_RE or SP_WE high SHALL be one accepted request; SP_ACK high exactly the next cycle; back-to-back requests give back-to-back ACKs.
REQ-019 SP_DO SHALL be 0 in every cycle SP_ACK is low, and after writes or errors.
REQ-020 SP_RE and SP_WE high together SHALL cause no state change, SP_DO=0, SP_ERR=1.
REQ-021 Unmapped read, write to addresses 0-2, or scratch write while not UNLOCKED SHALL have no effect, with SP_ERR=1.
REQ-022 Scratch writes SHALL update only bytes with SP_BE set; SP_BE=0 is a legal no-op write with SP_ERR=0.
REQ-023 Lock FSM states LOCKED, KEY1_OK, UNLOCKED; CTRL write with SP_BE=4'hF and SP_DI=32'h0000_C0DE in LOCKED -> KEY1_OK.
REQ-024 In KEY1_OK, CTRL write with SP_BE=4'hF and SP_DI=32'h0000_5AFE -> UNLOCKED; any other accepted request -> LOCKED; the request itself is still serviced.
REQ-025 In UNLOCKED, CTRL write with SP_DI[0]=1 -> LOCKED; other CTRL writes ignored; CTRL writes never set SP_ERR.
REQ-026 CTRL read SHALL return {29'b0, state[1:0], locked}; encoding LOCKED=0, KEY1_OK=1, UNLOCKED=2; locked=1 unless UNLOCKED.
REQ-027 State transitions and register writes SHALL take effect at the accepting edge; a read in the following cycle sees new values.

Reset
REQ-028 On OPB_RST_N low: SP_DO=0, SP_ACK=0, SP_ERR=0, WR_CNT=0, scratch[i]=32'h5A5A_0000+i; FSM enters LOCKED if LOCK_AT_RESET=1, else UNLOCKED.
REQ-029 Reset mid-request SHALL drop the pending ACK; no ACK SHALL be generated for a request accepted at or before reset.

Configuration
REQ-030 With SP_WR_COUNTER_EN defined: WR_CNT counts successful scratch writes, including SP_BE=0 writes, 32-bit wrap; any write to address 4 clears it, no error; a clear and a count in the same cycle cannot occur.
REQ-031 Without SP_WR_COUNTER_EN: address 4 is unmapped and no counter logic is present.

Structure
REQ-032 Shared package opb_scratch_pkg SHALL hold the address constants, the lock-state typedef, and the KEY1/KEY2 constants.
REQ-033 The lock FSM SHALL be a sub-module opb_scratch_lock with inputs ctrl_wr, other_req, wdata, be and outputs state, locked.

Verification
REQ-034 Reset, then read addresses 0/1/2/3 -> ACK one cycle after each; SP_DO 32'h1234_5678, 32'h0000_0050, 32'h2025_0714, 32'h0000_0001; ERR=0.
REQ-035 While locked, write scratch[0]=32'hDEAD_BEEF -> ERR=1; reading address 5 returns 32'h5A5A_0000.
REQ-036 Write CTRL 32'h0000_C0DE then 32'h0000_5AFE -> CTRL reads 32'h0000_0004; then write address 5 with SP_BE=4'b0011, SP_DI=32'h1111_2222 -> reads 32'h5A5A_2222.
REQ-037 Write CTRL 32'h0000_C0DE, read address 0, write CTRL 32'h0000_5AFE -> CTRL reads 32'h0000_0001.
REQ-038 Assert SP_RE and SP_WE together to address 5 -> ERR=1, DO=0, no change; read address 31 -> ERR=1.
REQ-039 SP_WR_COUNTER_EN defined, unlocked: 3 scratch writes -> WR_CNT reads 3; write address 4 -> reads 0; reset asserted during an ACK cycle -> ACK=0 immediately.
